// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT,
        HOLD
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0000;
    localparam int unsigned PC_INC         = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset > flush > stall (hold) > load > bubble.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(FETCH_NOP_INST)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc4_o,
    output logic [INST_W-1:0] inst_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic [INST_W-1:0] inst_q, inst_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end else if (!stall_i) begin
            if (load_i) begin
                valid_d = 1'b1;
                pc_d    = pc_i;
                pc4_d   = pc_i + ADDR_W'(PC_INC);
                inst_d  = inst_i;
            end else begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= ADDR_W'(PC_INC);
            inst_q  <= NOP_INST;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues the PC to instruction memory and loads IF/ID.
// Defining FETCH_PERF_CNT_EN adds saturating accept / miss-cycle counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(FETCH_NOP_INST)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_stall_o,
    input  logic              id_stall_i,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_data_i,
    output logic              ifid_valid_o,
    output logic [ADDR_W-1:0] ifid_pc_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic [INST_W-1:0] ifid_inst_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_o,
    output logic [31:0]       perf_miss_o
`endif
);

    fetch_state_e      state_q, state_d;
    fetch_state_e      done_state;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] buf_q, buf_d;
    logic              req;
    logic              accept;
    logic [ADDR_W-1:0] acc_pc;
    logic [INST_W-1:0] acc_inst;

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        addr_d      = addr_q;
        buf_d       = buf_q;
        req         = 1'b0;
        imem_addr_o = pc_i;
        accept      = 1'b0;
        acc_pc      = pc_i;
        acc_inst    = imem_data_i;
        // A finished transaction drops to IDLE if fetching was disabled meanwhile.
        done_state  = start_i ? RUN : IDLE;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                req = !(id_stall_i && !flush_i);
                if (req && imem_ack_i) begin
                    accept = !id_stall_i;
                    state_d = done_state;
                end else if (req) begin
                    addr_d  = pc_i;
                    kill_d  = flush_i;
                    state_d = WAIT;
                end else begin
                    state_d = done_state;
                end
            end
            WAIT: begin
                req         = 1'b1;
                imem_addr_o = addr_q;
                acc_pc      = addr_q;
                if (imem_ack_i) begin
                    kill_d = 1'b0;
                    if (kill_q || flush_i) begin
                        state_d = done_state;
                    end else if (!id_stall_i) begin
                        accept  = 1'b1;
                        state_d = done_state;
                    end else begin
                        buf_d   = imem_data_i;
                        state_d = HOLD;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                imem_addr_o = addr_q;
                acc_pc      = addr_q;
                acc_inst    = buf_q;
                if (flush_i) begin
                    state_d = done_state;
                end else if (!id_stall_i) begin
                    accept  = 1'b1;
                    state_d = done_state;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    assign imem_req_o = req;
    assign pc_stall_o = !(accept || flush_i);

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .NOP_INST(NOP_INST)
    ) u_ifid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .flush_i(flush_i),
        .stall_i(id_stall_i),
        .load_i (accept),
        .pc_i   (acc_pc),
        .inst_i (acc_inst),
        .valid_o(ifid_valid_o),
        .pc_o   (ifid_pc_o),
        .pc4_o  (ifid_pc4_o),
        .inst_o (ifid_inst_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_miss_q, perf_miss_d;

    always_comb begin
        perf_fetch_d = accept ? sat_inc32(perf_fetch_q) : perf_fetch_q;
        perf_miss_d  = (state_q == WAIT) ? sat_inc32(perf_miss_q) : perf_miss_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q <= '0;
            perf_miss_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_miss_q  <= perf_miss_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_miss_o  = perf_miss_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: variable-latency memory, PC register and
// a transaction-level reference model; directed scenarios then random traffic.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, start, id_stall, flush, ack;
    logic [31:0] pc, data;
    logic        req, pc_stall, ifid_valid;
    logic [31:0] addr_o, ifid_pc, ifid_pc4, ifid_inst;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W  (32),
        .INST_W  (32),
        .NOP_INST(NOP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pc_i        (pc),
        .pc_stall_o  (pc_stall),
        .id_stall_i  (id_stall),
        .flush_i     (flush),
        .imem_req_o  (req),
        .imem_addr_o (addr_o),
        .imem_ack_i  (ack),
        .imem_data_i (data),
        .ifid_valid_o(ifid_valid),
        .ifid_pc_o   (ifid_pc),
        .ifid_pc4_o  (ifid_pc4),
        .ifid_inst_o (ifid_inst)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // environment: branch target, memory latency control and memory state
    logic [31:0] br_target;
    int          force_lat;
    logic        mem_busy;
    int          mem_rem;
    logic [31:0] mem_addr;

    // reference model: fetch enabled, outstanding request, parked instruction, IF/ID
    logic        m_known, m_on, m_pend, m_pkill, m_held;
    logic [31:0] m_paddr, m_hdata;
    logic        m_valid;
    logic [31:0] m_pc, m_inst;

    logic        last_req, last_stall;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 1'b0; m_pend = 1'b0; m_pkill = 1'b0; m_held = 1'b0;
        m_paddr = '0; m_hdata = '0;
        m_valid = 1'b0; m_pc = '0; m_inst = NOP;
    endtask

    // One clock cycle: inputs already set by the caller at posedge+1.
    task automatic step();
        logic        e_req, dlv, e_stall;
        logic [31:0] e_addr, d_pc, d_inst;
        logic        n_on, n_pend, n_pkill, n_held;
        logic [31:0] n_paddr, n_hdata;
        logic        nb_busy;
        int          nb_rem, lat;
        logic [31:0] nb_addr;

        #1;
        ack = 1'b0;
        data = $urandom;
        nb_busy = mem_busy; nb_rem = mem_rem; nb_addr = mem_addr;
        if (!rst) begin
            if (mem_busy) begin
                chk("mem_req_held", {31'b0, req}, 32'd1);
                chk("mem_addr_stable", addr_o, mem_addr);
                if (mem_rem == 0) begin
                    ack = 1'b1; nb_busy = 1'b0;
                end else begin
                    nb_rem = mem_rem - 1;
                end
            end else if (req) begin
                lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                nb_addr = addr_o;
                if (lat == 0) ack = 1'b1;
                else begin nb_busy = 1'b1; nb_rem = lat - 1; end
            end
            if (ack) data = mem_word(mem_busy ? mem_addr : addr_o);
        end
        #1;

        e_req = 1'b0; e_addr = pc; dlv = 1'b0; d_pc = pc; d_inst = data;
        n_on = m_on; n_pend = m_pend; n_pkill = m_pkill; n_held = m_held;
        n_paddr = m_paddr; n_hdata = m_hdata;
        if (!m_on) begin
            n_on = start;
        end else if (m_held) begin
            if (flush) begin
                n_held = 1'b0; n_on = start;
            end else if (!id_stall) begin
                dlv = 1'b1; d_pc = m_paddr; d_inst = m_hdata; n_held = 1'b0; n_on = start;
            end
        end else if (m_pend) begin
            e_req = 1'b1; e_addr = m_paddr;
            if (ack) begin
                n_pend = 1'b0; n_pkill = 1'b0;
                if (m_pkill || flush) n_on = start;
                else if (!id_stall) begin dlv = 1'b1; d_pc = m_paddr; n_on = start; end
                else begin n_held = 1'b1; n_hdata = data; end
            end else if (flush) begin
                n_pkill = 1'b1;
            end
        end else begin
            e_req = !(id_stall && !flush);
            if (e_req && ack) begin
                dlv = !id_stall; n_on = start;
            end else if (e_req) begin
                n_pend = 1'b1; n_paddr = pc; n_pkill = flush;
            end else begin
                n_on = start;
            end
        end
        e_stall = !(dlv || flush);

        if (m_known) begin
            chk("imem_req_o", {31'b0, req}, {31'b0, e_req});
            if (e_req) chk("imem_addr_o", addr_o, e_addr);
            chk("pc_stall_o", {31'b0, pc_stall}, {31'b0, e_stall});
        end
        last_req = req; last_stall = pc_stall; last_addr = addr_o;

        @(posedge clk);
        #1;
        if (rst) begin
            pc = '0;
            mem_busy = 1'b0; mem_rem = 0; mem_addr = '0;
            model_reset();
            m_known = 1'b1;
        end else begin
            if (!last_stall) pc = flush ? br_target : pc + 32'd4;
            mem_busy = nb_busy; mem_rem = nb_rem; mem_addr = nb_addr;
            m_on = n_on; m_pend = n_pend; m_pkill = n_pkill; m_held = n_held;
            m_paddr = n_paddr; m_hdata = n_hdata;
            if (flush) begin
                m_valid = 1'b0; m_inst = NOP;
            end else if (!id_stall) begin
                if (dlv) begin m_valid = 1'b1; m_pc = d_pc; m_inst = d_inst; end
                else begin m_valid = 1'b0; m_inst = NOP; end
            end
        end
        if (m_known) begin
            chk("ifid_valid_o", {31'b0, ifid_valid}, {31'b0, m_valid});
            chk("ifid_pc_o", ifid_pc, m_pc);
            chk("ifid_pc4_o", ifid_pc4, m_pc + 32'd4);
            chk("ifid_inst_o", ifid_inst, m_inst);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; id_stall = 1'b0; flush = 1'b0;
        pc = '0; br_target = '0; ack = 1'b0; data = '0; force_lat = 0;
        mem_busy = 1'b0; mem_rem = 0; mem_addr = '0;
        m_known = 1'b0; model_reset();
        last_req = 1'b0; last_stall = 1'b0; last_addr = '0;
        @(posedge clk); #1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc4, 32'h4);
        chk("rst_inst", ifid_inst, NOP);

        // zero-wait memory
        start = 1'b1; force_lat = 0;
        step();
        chk("idle_req", {31'b0, last_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("zw_stall", {31'b0, last_stall}, 32'd0);
            chk("zw_pc", ifid_pc, 32'(4 * i));
            chk("zw_pc4", ifid_pc4, 32'(4 * i + 4));
            chk("zw_valid", {31'b0, ifid_valid}, 32'd1);
        end

        // three-cycle miss at 0x10
        pc = 32'h10; force_lat = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("miss_addr", last_addr, 32'h10);
            chk("miss_stall", {31'b0, last_stall}, 32'd1);
            chk("miss_bubble", {31'b0, ifid_valid}, 32'd0);
        end
        step();
        chk("miss_valid", {31'b0, ifid_valid}, 32'd1);
        chk("miss_pc", ifid_pc, 32'h10);
        chk("miss_inst", ifid_inst, mem_word(32'h10));

        // flush in the second cycle of a miss at 0x20
        pc = 32'h20; force_lat = 3;
        step();
        force_lat = 0; flush = 1'b1; br_target = 32'h100;
        step();
        chk("flush_stall", {31'b0, last_stall}, 32'd0);
        flush = 1'b0;
        step(); step();
        chk("flush_discard", {31'b0, ifid_valid}, 32'd0);
        step();
        chk("flush_target_addr", last_addr, 32'h100);
        chk("flush_target_pc", ifid_pc, 32'h100);
        chk("flush_target_valid", {31'b0, ifid_valid}, 32'd1);

        // ack at 0x30 while ID stalls for two cycles
        pc = 32'h30; force_lat = 1;
        step();
        id_stall = 1'b1;
        step();
        chk("hold_stall", {31'b0, last_stall}, 32'd1);
        step();
        chk("hold_req", {31'b0, last_req}, 32'd0);
        chk("hold_valid", {31'b0, ifid_valid}, 32'd0);
        id_stall = 1'b0;
        step();
        chk("hold_norefetch", {31'b0, last_req}, 32'd0);
        chk("hold_pc", ifid_pc, 32'h30);
        chk("hold_inst", ifid_inst, mem_word(32'h30));

        // reset while waiting on memory
        pc = 32'h40; force_lat = 3;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstw_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rstw_inst", ifid_inst, NOP);
        chk("rstw_pc", ifid_pc, 32'h0);
        force_lat = 0;
        step();
        chk("rstw_req", {31'b0, last_req}, 32'd0);
        step();
        chk("rstw_resume_pc", ifid_pc, 32'h0);
        chk("rstw_resume_valid", {31'b0, ifid_valid}, 32'd1);

        // PC wrap
        pc = 32'hFFFF_FFFC;
        step();
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc4, 32'h0);

        // random traffic
        force_lat = -1;
        for (int c = 0; c < 3000; c++) begin
            start     = ($urandom_range(0, 9) != 0);
            id_stall  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            br_target = $urandom & 32'hFFFF_FFFC;
            step();
        end
        rst = 1'b0; flush = 1'b0; id_stall = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
